alu_writeback: RTL and testbench
================================

Name: alu_writeback

Overview:
- Stage directly downstream of the CPU's combinational ALU.
- Registers the ALU result and flags, and owns the architectural status register SREG (I T H S V N Z C).
- Drives the 8-bit register-file write port; splits 16-bit results (ADIW/SBIW) into two byte writes over two cycles, stalling upstream meanwhile.
- Also services SREG writes (OUT SREG), BSET/BCLR, BST, and interrupt-entry/RETI I-flag control.

Parameters:
- SREG_RST, 8'h00, SREG value after reset.

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  reset, asynchronous, active-low
- wb_valid  input  1  ALU result/flags valid this cycle
- wb_word  input  1  result is 16-bit (register pair)
- wb_wen  input  1  write result to register file (0 for CP/CPC/CPI/TST-style compares)
- wb_dst  input  5  destination register (word ops: pair low register)
- ro  input  16  ALU result
- cf, zf, nf, vf, sf, hf  input  1 each  ALU flags
- flag_mask  input  6  per-flag update enable {H,S,V,N,Z,C}
- bset  input  1  set SREG bit bit_sel
- bclr  input  1  clear SREG bit bit_sel
- bit_sel  input  3  SREG bit index for bset/bclr
- bst  input  1  load T from bst_val
- bst_val  input  1  bit value for BST
- sreg_we  input  1  full SREG write (OUT)
- sreg_wdata  input  8  SREG write data
- irq_clr_i  input  1  interrupt entry: clear I
- reti_set_i  input  1  RETI: set I
- sreg  output  8  current SREG {I,T,H,S,V,N,Z,C}
- rf_we  output  1  register-file write strobe
- rf_addr  output  5  register-file write address
- rf_wdata  output  8  register-file write data
- stall  output  1  upstream must hold; inputs ignored

Behaviour:
- Reset (rst_n low, async): sreg=SREG_RST; rf_we=0, rf_addr=0, rf_wdata=0; stall=0; state=IDLE; hi_byte latch=0. Reset mid-word-write aborts the high-byte write.
- All outputs are registered. Latency is 1 cycle from input to rf_* / sreg.
- States:
  - IDLE: accepts inputs.
  - HI: second byte of a word write is pending; stall=1.
- IDLE, wb_valid=1, wb_word=0:
  - rf_we<=wb_wen, rf_addr<=wb_dst, rf_wdata<=ro[7:0].
  - Flags with a mask bit set update from cf..hf; others unchanged.
- IDLE, wb_valid=1, wb_word=1:
  - rf_we<=wb_wen, rf_addr<={wb_dst[4:1],0}, rf_wdata<=ro[7:0].
  - Latch ro[15:8]; flags update as for a byte op.
  - Go to HI, stall<=1.
- HI:
  - rf_we<=1, rf_addr<={latched pair,1}, rf_wdata<=latched high byte.
  - stall<=0, go to IDLE. All inputs except irq_clr_i are ignored.
- Word op with wb_wen=0: still takes the HI cycle, with rf_we=0 in both cycles.
- wb_valid=0 in IDLE: rf_we<=0; rf_addr/rf_wdata hold.
- SREG update priority, per bit, highest first:
  1. irq_clr_i (bit 7 only; honoured in any state)
  2. sreg_we
  3. bclr
  4. bset
  5. bst (bit 6)
  6. reti_set_i (bit 7)
  7. ALU flag mask (bits 5:0)
- Non-interrupt SREG sources are honoured only in IDLE.
- bset and bclr asserted together on the same bit: bclr wins.
- sreg_we with wb_valid in the same cycle: sreg_wdata wins for all bits; the register write still occurs.
- wb_dst is used unmodified for byte ops; word pairs cannot wrap past r31 (the address is forced to even/odd).

Test Plan:
1. Byte: wb_valid=1, wb_dst=5, ro=16'h00A3, nf=1, zf=0, flag_mask=6'b011111, sreg=0 -> next cycle rf_we=1, rf_addr=5, rf_wdata=A3, sreg=8'h04 (N set).
2. Word: wb_word=1, wb_dst=24, ro=16'h1234, cf=1, mask C only -> cycle 1: rf_addr=24, data=34, stall=1, C=1. Cycle 2: rf_addr=25, data=12, stall=0. A wb_valid presented during cycle 2 is ignored.
3. Compare: wb_wen=0, zf=1, mask=Z -> rf_we=0, sreg[1]=1, register file untouched.
4. Priority: sreg_we=1 data=8'h80, simultaneous wb_valid with cf=1 mask=C -> sreg=8'h80 and the register write occurs. Then bset=bclr=1, bit_sel=0 -> C=0.
5. Interrupt: irq_clr_i during HI with I=1 -> I=0 next cycle; the high-byte write still completes.
6. Async reset asserted in HI -> immediately rf_we=0, stall=0, sreg=SREG_RST. After release: IDLE, no pending high byte written.

Source files
------------

// File: rtl/alu_writeback.sv
// -----------------------------------------------------------------------------
// alu_writeback
//
// Purpose:
//   This stage sits directly after the CPU's combinational ALU. It registers
//   the ALU result and flags, and it owns the architectural status register
//   SREG {I,T,H,S,V,N,Z,C}. It drives the 8-bit register-file write port.
//   A 16-bit result (ADIW/SBIW) goes out as two byte writes on consecutive
//   cycles. The stage stalls upstream while the high byte is pending.
//   It also handles full SREG writes, BSET/BCLR, BST, and the I-flag control
//   used by interrupt entry and RETI.
//
// Ports:
//   clk         system clock, rising edge
//   rst_n       asynchronous active-low reset
//   wb_valid    ALU result/flags valid this cycle
//   wb_word     result is 16-bit (register pair)
//   wb_wen      write the result to the register file (0 for compares)
//   wb_dst      destination register (word ops: low register of the pair)
//   ro          ALU result
//   cf..hf      ALU flags
//   flag_mask   per-flag update enable {H,S,V,N,Z,C}
//   bset/bclr   set/clear SREG bit bit_sel
//   bit_sel     SREG bit index for bset/bclr
//   bst/bst_val load T from bst_val
//   sreg_we     full SREG write with sreg_wdata
//   irq_clr_i   interrupt entry: clear I (honoured in every state)
//   reti_set_i  RETI: set I
//   sreg        current SREG
//   rf_we       register-file write strobe
//   rf_addr     register-file write address
//   rf_wdata    register-file write data
//   stall       upstream must hold; inputs are ignored while it is high
// -----------------------------------------------------------------------------
module alu_writeback #(
  parameter logic [7:0] SREG_RST = 8'h00
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       wb_valid,
  input  logic       wb_word,
  input  logic       wb_wen,
  input  logic [4:0] wb_dst,
  input  logic [15:0] ro,
  input  logic       cf,
  input  logic       zf,
  input  logic       nf,
  input  logic       vf,
  input  logic       sf,
  input  logic       hf,
  input  logic [5:0] flag_mask,
  input  logic       bset,
  input  logic       bclr,
  input  logic [2:0] bit_sel,
  input  logic       bst,
  input  logic       bst_val,
  input  logic       sreg_we,
  input  logic [7:0] sreg_wdata,
  input  logic       irq_clr_i,
  input  logic       reti_set_i,
  output logic [7:0] sreg,
  output logic       rf_we,
  output logic [4:0] rf_addr,
  output logic [7:0] rf_wdata,
  output logic       stall
);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_HI   = 1'b1
  } state_t;

  state_t     state_r, state_nxt_s;
  logic [7:0] hi_byte_r, hi_byte_nxt_s;
  logic [3:0] hi_pair_r, hi_pair_nxt_s;
  logic       hi_wen_r, hi_wen_nxt_s;
  logic [7:0] sreg_r, sreg_nxt_s;
  logic       rf_we_r, rf_we_nxt_s;
  logic [4:0] rf_addr_r, rf_addr_nxt_s;
  logic [7:0] rf_wdata_r, rf_wdata_nxt_s;
  logic       stall_r, stall_nxt_s;

  // Flags whose mask bit is set take the ALU value. The other flags keep their old value.
  function automatic logic [5:0] merge_flags(input logic [5:0] mask,
                                             input logic [5:0] alu,
                                             input logic [5:0] cur);
    merge_flags = (mask & alu) | (~mask & cur);
  endfunction

  // The SREG sources below are layered from lowest to highest priority, so a
  // later stage overrides an earlier one on the bits it touches.
  // irq_clr_i is not in this chain. It is applied last, and in every state.
  logic [5:0] alu_flags_s;
  logic [7:0] sel_oh_s;
  logic [7:0] sreg_flag_s;
  logic [7:0] sreg_reti_s;
  logic [7:0] sreg_bst_s;
  logic [7:0] sreg_bset_s;
  logic [7:0] sreg_bclr_s;
  logic [7:0] sreg_idle_s;

  assign alu_flags_s = {hf, sf, vf, nf, zf, cf};
  assign sel_oh_s    = 8'h01 << bit_sel;
  assign sreg_flag_s = wb_valid ? {sreg_r[7:6], merge_flags(flag_mask, alu_flags_s, sreg_r[5:0])}
                                : sreg_r;
  assign sreg_reti_s = reti_set_i ? {1'b1, sreg_flag_s[6:0]} : sreg_flag_s;
  assign sreg_bst_s  = bst ? {sreg_reti_s[7], bst_val, sreg_reti_s[5:0]} : sreg_reti_s;
  assign sreg_bset_s = bset ? (sreg_bst_s | sel_oh_s) : sreg_bst_s;
  assign sreg_bclr_s = bclr ? (sreg_bset_s & ~sel_oh_s) : sreg_bset_s;
  assign sreg_idle_s = sreg_we ? sreg_wdata : sreg_bclr_s;

  // Next-state logic: the write-port sequencing and the SREG update.
  always_comb begin
    state_nxt_s    = state_r;
    hi_byte_nxt_s  = hi_byte_r;
    hi_pair_nxt_s  = hi_pair_r;
    hi_wen_nxt_s   = hi_wen_r;
    rf_we_nxt_s    = 1'b0;
    rf_addr_nxt_s  = rf_addr_r;
    rf_wdata_nxt_s = rf_wdata_r;
    stall_nxt_s    = 1'b0;
    sreg_nxt_s     = sreg_r;

    case (state_r)
      ST_IDLE: begin
        sreg_nxt_s = sreg_idle_s;
        if (wb_valid) begin
          rf_we_nxt_s    = wb_wen;
          rf_wdata_nxt_s = ro[7:0];
          if (wb_word) begin
            // Force the pair onto an even/odd boundary so it cannot wrap past r31.
            rf_addr_nxt_s = {wb_dst[4:1], 1'b0};
            hi_byte_nxt_s = ro[15:8];
            hi_pair_nxt_s = wb_dst[4:1];
            hi_wen_nxt_s  = wb_wen;
            state_nxt_s   = ST_HI;
            stall_nxt_s   = 1'b1;
          end else begin
            rf_addr_nxt_s = wb_dst;
          end
        end else begin
          rf_we_nxt_s = 1'b0;
        end
      end
      ST_HI: begin
        // The high byte inherits the write enable of its word op. A word
        // compare therefore writes nothing in either cycle.
        rf_we_nxt_s    = hi_wen_r;
        rf_addr_nxt_s  = {hi_pair_r, 1'b1};
        rf_wdata_nxt_s = hi_byte_r;
        state_nxt_s    = ST_IDLE;
        stall_nxt_s    = 1'b0;
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase

    // Interrupt entry has the highest priority on I, in every state.
    if (irq_clr_i) begin
      sreg_nxt_s[7] = 1'b0;
    end else begin
      sreg_nxt_s[7] = sreg_nxt_s[7];
    end
  end

  // State, latches and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= ST_IDLE;
      hi_byte_r  <= 8'h00;
      hi_pair_r  <= 4'h0;
      hi_wen_r   <= 1'b0;
      sreg_r     <= SREG_RST;
      rf_we_r    <= 1'b0;
      rf_addr_r  <= 5'd0;
      rf_wdata_r <= 8'h00;
      stall_r    <= 1'b0;
    end else begin
      state_r    <= state_nxt_s;
      hi_byte_r  <= hi_byte_nxt_s;
      hi_pair_r  <= hi_pair_nxt_s;
      hi_wen_r   <= hi_wen_nxt_s;
      sreg_r     <= sreg_nxt_s;
      rf_we_r    <= rf_we_nxt_s;
      rf_addr_r  <= rf_addr_nxt_s;
      rf_wdata_r <= rf_wdata_nxt_s;
      stall_r    <= stall_nxt_s;
    end
  end

  assign sreg     = sreg_r;
  assign rf_we    = rf_we_r;
  assign rf_addr  = rf_addr_r;
  assign rf_wdata = rf_wdata_r;
  assign stall    = stall_r;

endmodule

// File: tb/tb_alu_writeback.sv
// -----------------------------------------------------------------------------
// tb_alu_writeback
//
// This bench drives directed vectors into alu_writeback. Each vector carries
// hand-computed expected outputs, and the bench pushes that expectation into
// a scoreboard queue, tagged with the cycle in which the output must appear.
// A monitor on the falling edge pops the entries that are due and compares
// them with the DUT outputs.
// -----------------------------------------------------------------------------
module tb_alu_writeback;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wb_valid, wb_word, wb_wen;
  logic [4:0]  wb_dst;
  logic [15:0] ro;
  logic        cf, zf, nf, vf, sf, hf;
  logic [5:0]  flag_mask;
  logic        bset, bclr;
  logic [2:0]  bit_sel;
  logic        bst, bst_val;
  logic        sreg_we;
  logic [7:0]  sreg_wdata;
  logic        irq_clr_i, reti_set_i;
  logic [7:0]  sreg;
  logic        rf_we;
  logic [4:0]  rf_addr;
  logic [7:0]  rf_wdata;
  logic        stall;

  alu_writeback #(.SREG_RST(8'h00)) dut (
    .clk(clk), .rst_n(rst_n), .wb_valid(wb_valid), .wb_word(wb_word),
    .wb_wen(wb_wen), .wb_dst(wb_dst), .ro(ro), .cf(cf), .zf(zf), .nf(nf),
    .vf(vf), .sf(sf), .hf(hf), .flag_mask(flag_mask), .bset(bset),
    .bclr(bclr), .bit_sel(bit_sel), .bst(bst), .bst_val(bst_val),
    .sreg_we(sreg_we), .sreg_wdata(sreg_wdata), .irq_clr_i(irq_clr_i),
    .reti_set_i(reti_set_i), .sreg(sreg), .rf_we(rf_we), .rf_addr(rf_addr),
    .rf_wdata(rf_wdata), .stall(stall)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         due;
    int         id;
    logic       we;
    logic [4:0] addr;
    logic [7:0] data;
    logic [7:0] sr;
    logic       st;
  } exp_t;

  exp_t sb_q[$];
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int id, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s vec%0d: got %h expected %h", nm, id, act, exp);
    end
  endtask

  // Scoreboard monitor: pop every entry that is due in this cycle and compare it.
  always @(negedge clk) begin
    while (sb_q.size() > 0 && sb_q[0].due <= cyc) begin
      exp_t e;
      e = sb_q.pop_front();
      if (e.due < cyc) begin
        checks++;
        failures++;
        $display("FAIL slot vec%0d: checked at cycle %0d expected at cycle %0d", e.id, cyc, e.due);
      end else begin
        chk("rf_we",    e.id, {7'd0, rf_we},   {7'd0, e.we});
        chk("rf_addr",  e.id, {3'd0, rf_addr}, {3'd0, e.addr});
        chk("rf_wdata", e.id, rf_wdata,        e.data);
        chk("sreg",     e.id, sreg,            e.sr);
        chk("stall",    e.id, {7'd0, stall},   {7'd0, e.st});
      end
    end
  end

  task automatic clear_inputs();
    wb_valid = 1'b0; wb_word = 1'b0; wb_wen = 1'b0; wb_dst = 5'd0; ro = 16'h0000;
    cf = 1'b0; zf = 1'b0; nf = 1'b0; vf = 1'b0; sf = 1'b0; hf = 1'b0;
    flag_mask = 6'b000000; bset = 1'b0; bclr = 1'b0; bit_sel = 3'd0;
    bst = 1'b0; bst_val = 1'b0; sreg_we = 1'b0; sreg_wdata = 8'h00;
    irq_clr_i = 1'b0; reti_set_i = 1'b0;
  endtask

  // Queue the expected outputs for the next cycle, let the edge happen, then clear the inputs.
  task automatic step(input int id, input logic we, input logic [4:0] addr,
                      input logic [7:0] data, input logic [7:0] sr, input logic st);
    exp_t e;
    e.due = cyc + 1; e.id = id; e.we = we; e.addr = addr; e.data = data; e.sr = sr; e.st = st;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    clear_inputs();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    clear_inputs();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_rf_we",    0, {7'd0, rf_we},   8'h00);
    chk("rst_rf_addr",  0, {3'd0, rf_addr}, 8'h00);
    chk("rst_rf_wdata", 0, rf_wdata,        8'h00);
    chk("rst_sreg",     0, sreg,            8'h00);
    chk("rst_stall",    0, {7'd0, stall},   8'h00);
    rst_n = 1'b1;

    // Byte op: N is set, all other flags are 0.
    wb_valid = 1'b1; wb_wen = 1'b1; wb_dst = 5'd5; ro = 16'h00A3; nf = 1'b1; flag_mask = 6'b011111;
    step(1, 1'b1, 5'd5, 8'hA3, 8'h04, 1'b0);

    // Word op: the low byte goes out first and C is set.
    wb_valid = 1'b1; wb_word = 1'b1; wb_wen = 1'b1; wb_dst = 5'd24; ro = 16'h1234; cf = 1'b1; flag_mask = 6'b000001;
    step(2, 1'b1, 5'd24, 8'h34, 8'h05, 1'b1);
    // HI cycle: the op offered here is ignored.
    wb_valid = 1'b1; wb_wen = 1'b1; wb_dst = 5'd3; ro = 16'h00FF; flag_mask = 6'b111111;
    cf = 1'b1; zf = 1'b1; nf = 1'b1; vf = 1'b1; sf = 1'b1; hf = 1'b1; bset = 1'b1; bit_sel = 3'd7;
    step(3, 1'b1, 5'd25, 8'h12, 8'h05, 1'b0);
    // Idle: rf_we drops and the address and data hold.
    step(4, 1'b0, 5'd25, 8'h12, 8'h05, 1'b0);

    // Compare: no register write, Z is set.
    wb_valid = 1'b1; wb_wen = 1'b0; wb_dst = 5'd7; ro = 16'h0055; zf = 1'b1; flag_mask = 6'b000010;
    step(5, 1'b0, 5'd7, 8'h55, 8'h07, 1'b0);

    // The full SREG write beats the ALU flags, and the register write still happens.
    sreg_we = 1'b1; sreg_wdata = 8'h80;
    wb_valid = 1'b1; wb_wen = 1'b1; wb_dst = 5'd9; ro = 16'h0011; cf = 1'b1; flag_mask = 6'b000001;
    step(6, 1'b1, 5'd9, 8'h11, 8'h80, 1'b0);
    bset = 1'b1; bit_sel = 3'd0;
    step(7, 1'b0, 5'd9, 8'h11, 8'h81, 1'b0);
    bset = 1'b1; bclr = 1'b1; bit_sel = 3'd0;
    step(8, 1'b0, 5'd9, 8'h11, 8'h80, 1'b0);
    bst = 1'b1; bst_val = 1'b1;
    step(9, 1'b0, 5'd9, 8'h11, 8'hC0, 1'b0);
    // bclr on T beats bst.
    bclr = 1'b1; bit_sel = 3'd6; bst = 1'b1; bst_val = 1'b1;
    step(10, 1'b0, 5'd9, 8'h11, 8'h80, 1'b0);
    // Interrupt clear beats RETI.
    irq_clr_i = 1'b1; reti_set_i = 1'b1;
    step(11, 1'b0, 5'd9, 8'h11, 8'h00, 1'b0);
    reti_set_i = 1'b1;
    step(12, 1'b0, 5'd9, 8'h11, 8'h80, 1'b0);
    // Interrupt clear beats the full SREG write.
    sreg_we = 1'b1; sreg_wdata = 8'hFF; irq_clr_i = 1'b1;
    step(13, 1'b0, 5'd9, 8'h11, 8'h7F, 1'b0);
    sreg_we = 1'b1; sreg_wdata = 8'h80;
    step(14, 1'b0, 5'd9, 8'h11, 8'h80, 1'b0);

    // Word op with an odd destination is forced to 24/25. irq_clr_i in HI is honoured.
    wb_valid = 1'b1; wb_word = 1'b1; wb_wen = 1'b1; wb_dst = 5'd25; ro = 16'hABCD;
    step(15, 1'b1, 5'd24, 8'hCD, 8'h80, 1'b1);
    irq_clr_i = 1'b1; sreg_we = 1'b1; sreg_wdata = 8'hFF;
    step(16, 1'b1, 5'd25, 8'hAB, 8'h00, 1'b0);

    // Word compare at the top pair: no write in either cycle. RETI in HI is ignored.
    wb_valid = 1'b1; wb_word = 1'b1; wb_wen = 1'b0; wb_dst = 5'd31; ro = 16'hBEEF;
    step(17, 1'b0, 5'd30, 8'hEF, 8'h00, 1'b1);
    reti_set_i = 1'b1;
    step(18, 1'b0, 5'd31, 8'hBE, 8'h00, 1'b0);
    bset = 1'b1; bit_sel = 3'd3;
    step(19, 1'b0, 5'd31, 8'hBE, 8'h08, 1'b0);

    // Word op with all flags in the mask (only H set), then an async reset during HI.
    wb_valid = 1'b1; wb_word = 1'b1; wb_wen = 1'b1; wb_dst = 5'd2; ro = 16'h7766;
    hf = 1'b1; flag_mask = 6'b111111;
    step(20, 1'b1, 5'd2, 8'h66, 8'h20, 1'b1);
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("arst_rf_we",    21, {7'd0, rf_we},   8'h00);
    chk("arst_rf_addr",  21, {3'd0, rf_addr}, 8'h00);
    chk("arst_rf_wdata", 21, rf_wdata,        8'h00);
    chk("arst_sreg",     21, sreg,            8'h00);
    chk("arst_stall",    21, {7'd0, stall},   8'h00);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    // The high byte that was pending must never be written.
    step(22, 1'b0, 5'd0, 8'h00, 8'h00, 1'b0);
    step(23, 1'b0, 5'd0, 8'h00, 8'h00, 1'b0);

    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (sb_q.size() != 0) begin
      failures++;
      $display("FAIL drain: %0d entries left expected 0", sb_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
